// File: rtl/dt_pack.sv
// dt_pack: thresholds a distance map read from res RAM and packs the
// resulting binary image 16 pixels per word into the sti memory.
// Per word: 16 read cycles, one capture cycle, one write cycle.
module dt_pack #(
  parameter int IMG_W = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  thr,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        sti_wr,
  output logic [9:0]  sti_addr,
  output logic [15:0] sti_do,
  output logic [14:0] obj_cnt,
  output logic        done
);

  // Index of the final word of the image; the pass ends after writing it.
  localparam logic [9:0] LAST_W = 10'(IMG_W * IMG_W / 16 - 1);

  typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

  state_t      state;
  logic [7:0]  thr_lat;
  logic [9:0]  w;
  logic [3:0]  k;
  logic [15:0] word;
  logic        hit;

  // Read data always belongs to the pixel addressed on the previous cycle.
  assign hit = res_di > thr_lat;

  // Pass sequencer: all outputs are registered and updated with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      thr_lat  <= 8'd0;
      w        <= 10'd0;
      k        <= 4'd0;
      word     <= 16'd0;
      obj_cnt  <= 15'd0;
      res_rd   <= 1'b0;
      res_addr <= 14'd0;
      sti_wr   <= 1'b0;
      sti_addr <= 10'd0;
      sti_do   <= 16'd0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            thr_lat  <= thr;
            w        <= 10'd0;
            k        <= 4'd0;
            word     <= 16'd0;
            obj_cnt  <= 15'd0;
            res_rd   <= 1'b1;
            res_addr <= 14'd0;
            state    <= READ;
          end
        end
        READ: begin
          if (k != 4'd0) begin
            word[k - 4'd1] <= hit;
            obj_cnt        <= obj_cnt + {14'd0, hit};
          end
          if (k == 4'd15) begin
            res_rd   <= 1'b0;
            res_addr <= 14'd0;
            state    <= LAST;
          end else begin
            k        <= k + 4'd1;
            res_addr <= {w, k + 4'd1};
          end
        end
        LAST: begin
          word[15] <= hit;
          obj_cnt  <= obj_cnt + {14'd0, hit};
          sti_wr   <= 1'b1;
          sti_addr <= w;
          sti_do   <= {hit, word[14:0]};
          state    <= WRITE;
        end
        WRITE: begin
          sti_wr   <= 1'b0;
          sti_addr <= 10'd0;
          sti_do   <= 16'd0;
          if (w == LAST_W) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            w        <= w + 10'd1;
            k        <= 4'd0;
            res_rd   <= 1'b1;
            res_addr <= {w + 10'd1, 4'd0};
            state    <= READ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_pack.sv
// tb_dt_pack: randomized and directed passes of dt_pack against a
// behavioural model of the thresholded image, scoreboarded on sti writes.
module tb_dt_pack;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] obj_cnt;
  logic        done;

  logic [7:0]  ram [0:16383];
  logic [25:0] exp_q [$];
  logic [14:0] exp_rd;
  int          exp_obj;
  int          checks;
  int          errors;

  dt_pack #(.IMG_W(128)) dut (
    .clk(clk), .reset(reset), .start(start), .thr(thr),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .sti_wr(sti_wr), .sti_addr(sti_addr), .sti_do(sti_do),
    .obj_cnt(obj_cnt), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Distance-map RAM: data for the strobed address appears the next cycle.
  always @(posedge clk) begin
    if (res_rd) res_di <= ram[res_addr];
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference model: image word w bit k is set when pixel 16w+k exceeds t.
  task automatic build_expect(input logic [7:0] t);
    logic [15:0] wd;
    exp_q.delete();
    exp_obj = 0;
    for (int wi = 0; wi < 1024; wi++) begin
      wd = 16'd0;
      for (int b = 0; b < 16; b++) begin
        if (ram[wi * 16 + b] > t) begin
          wd[b] = 1'b1;
          exp_obj++;
        end
      end
      exp_q.push_back({10'(wi), wd});
    end
  endtask

  // Monitor: every write is popped against the scoreboard, reads must walk
  // pixels in order, and idle address/data buses must sit at zero.
  always @(negedge clk) begin
    if (reset) begin
      if (sti_wr) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_write", {6'd0, sti_addr, sti_do}, 32'hFFFFFFFF);
        end else begin
          check_output("sti_word", {6'd0, sti_addr, sti_do}, {6'd0, exp_q.pop_front()});
        end
      end else begin
        check_output("sti_idle_zero", {6'd0, sti_addr, sti_do}, 32'd0);
      end
      if (res_rd) begin
        check_output("res_addr_seq", {18'd0, res_addr}, {17'd0, exp_rd});
        exp_rd++;
      end else begin
        check_output("res_addr_idle", {18'd0, res_addr}, 32'd0);
      end
    end
  end

  // One pass: push expectations, pulse start, then follow it to done or to
  // an optional reset abort at cycle abort_n after the accepting edge.
  task automatic apply_stimulus(input logic [7:0] t, input int mid_n,
                                input logic [7:0] t_after, input int abort_n);
    int n;
    int rd_seen;
    int done_seen;
    logic got_done;
    build_expect(t);
    exp_rd = 15'd0;
    @(negedge clk);
    thr   = t;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    thr   = t_after;
    n = 0;
    got_done = 1'b0;
    while (n < 19000) begin
      @(posedge clk);
      n++;
      #1;
      start = (mid_n > 0 && n == mid_n);
      if (abort_n > 0 && n == abort_n) break;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (abort_n > 0) begin
      check_output("abort_write_active", {21'd0, sti_wr, sti_addr}, {21'd0, 1'b1, 10'd300});
      reset = 1'b0;
      #1;
      check_output("abort_outputs_zero",
                   {res_rd, sti_wr, done, 14'd0, sti_addr != 10'd0, sti_do != 16'd0, res_addr != 14'd0},
                   32'd0);
      check_output("abort_obj_cnt", {17'd0, obj_cnt}, 32'd0);
      exp_q.delete();
      done_seen = 0;
      repeat (5) begin
        @(posedge clk);
        #1;
        if (done || sti_wr) done_seen++;
      end
      check_output("abort_no_done", done_seen, 0);
      @(negedge clk);
      reset = 1'b1;
      rd_seen = 0;
      repeat (10) begin
        @(posedge clk);
        #1;
        if (res_rd) rd_seen++;
      end
      check_output("abort_waits_start", rd_seen, 0);
    end else begin
      check_output("done_seen", {31'd0, got_done}, 32'd1);
      check_output("pass_latency", n, 18432);
      check_output("obj_cnt", {17'd0, obj_cnt}, exp_obj);
      check_output("all_words_written", exp_q.size(), 0);
      @(posedge clk);
      #1;
      check_output("done_one_cycle", {31'd0, done}, 32'd0);
      rd_seen = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (res_rd || done) rd_seen++;
      end
      check_output("idle_after_done", rd_seen, 0);
      check_output("obj_cnt_hold", {17'd0, obj_cnt}, exp_obj);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_rd = 15'd0;
    exp_obj = 0;
    reset = 1'b0;
    start = 1'b0;
    thr   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_strobes", {29'd0, res_rd, sti_wr, done}, 32'd0);
    check_output("reset_buses", {8'd0, sti_addr, res_addr}, 32'd0);
    check_output("reset_data", {1'b0, obj_cnt, sti_do}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single set pixel 17, thr 0; reset lands during the write of word 300.
    for (int i = 0; i < 16384; i++) ram[i] = 8'd0;
    ram[17] = 8'd3;
    apply_stimulus(8'd0, 0, 8'd0, 18 * 300 + 17);

    // All-zero map, thr 0, with a stray start during the reads of word 5.
    ram[17] = 8'd0;
    apply_stimulus(8'd0, 95, 8'd0, 0);

    // Random map with a ramp in word 0; thr 8 then changed after acceptance.
    for (int i = 0; i < 16384; i++) ram[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) ram[i] = 8'(i + 1);
    ram[17] = 8'd3;
    apply_stimulus(8'd8, 0, 8'($urandom_range(0, 255)), 0);

    // Saturated map against the two highest thresholds.
    for (int i = 0; i < 16384; i++) ram[i] = 8'hFF;
    apply_stimulus(8'hFE, 0, 8'd0, 0);
    apply_stimulus(8'hFF, 0, 8'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
